// File: rtl/mult_iter32_if.sv
// Handshake and result bus between the EX-stage issue logic and mult_iter32.
interface mult_iter32_if;
  logic        start;
  logic        sign_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, sign_op, op_a, op_b, input busy, done, hi, lo);
  modport slave  (input start, sign_op, op_a, op_b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_iter32.sv
// Iterative radix-2 shift-add 32x32 multiplier producing HI/LO for MULT/MULTU.
// Optional signed support is compiled in with the SIGNED_MULT_EN macro.
module mult_iter32 #(
  parameter bit DONE_STICKY = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  mult_iter32_if.slave bus
);

`ifdef SIGNED_MULT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2, S_FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t      state, state_nxt;
  logic        busy, busy_nxt;
  logic        done, done_nxt;
  logic [4:0]  count;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] sum;

  // CLA32: 4-bit lookahead groups with a group-carry chain; returns {co, sum}.
  function automatic logic [32:0] cla32(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic        gg;
    logic        gp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int k = 0; k < 8; k++) begin
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
           (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp = &p[4*k +: 4];
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      c[4*k+4] = gg | (gp & c[4*k]);
    end
    return {c[32], p ^ c[31:0]};
  endfunction

  function automatic logic [31:0] twos32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] twos64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  assign sum = cla32(hi, mcand, 1'b0);

`ifdef SIGNED_MULT_EN
  logic neg_a, neg_b, neg;
  assign neg_a = bus.sign_op & bus.op_a[31];
  assign neg_b = bus.sign_op & bus.op_b[31];
  // 0x80000000 negates to itself, which is exactly its unsigned magnitude 2^31.
  assign mag_a = neg_a ? twos32(bus.op_a) : bus.op_a;
  assign mag_b = neg_b ? twos32(bus.op_b) : bus.op_b;
`else
  logic unused_sign;
  assign unused_sign = bus.sign_op;
  assign mag_a       = bus.op_a;
  assign mag_b       = bus.op_b;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_CALC;
`ifdef SIGNED_MULT_EN
      S_CALC: if (count == 5'd31) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
`else
      S_CALC: if (count == 5'd31) state_nxt = S_DONE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // busy/done are registered so done lands one cycle after the DONE state.
  always_comb begin
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = 1'b0;
    if (state == S_DONE)
      done_nxt = 1'b1;
    else if (DONE_STICKY && !(state == S_IDLE && bus.start))
      done_nxt = done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
`ifdef SIGNED_MULT_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          mcand <= mag_a;
          lo    <= mag_b;
          hi    <= '0;
          count <= '0;
`ifdef SIGNED_MULT_EN
          neg   <= neg_a ^ neg_b;
`endif
        end
        // The adder carry-out becomes hi[31]; the 64-bit result cannot overflow.
        S_CALC: begin
          if (lo[0]) begin
            hi <= sum[32:1];
            lo <= {sum[0], lo[31:1]};
          end else begin
            hi <= {1'b0, hi[31:1]};
            lo <= {hi[0], lo[31:1]};
          end
          count <= count + 5'd1;
        end
`ifdef SIGNED_MULT_EN
        S_FIX: if (neg) {hi, lo} <= twos64({hi, lo});
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;

endmodule

// File: tb/tb_mult_iter32.sv
// Self-checking bench for mult_iter32: table of products, latency, busy/done
// corner sequences, mid-operation reset and the sticky-done variant.
`timescale 1ns/1ps
module tb_mult_iter32;
`ifdef SIGNED_MULT_EN
  localparam int LAT = 34;
  localparam bit SG  = 1'b1;
`else
  localparam int LAT = 33;
  localparam bit SG  = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_iter32_if b0();
  mult_iter32_if b1();

  mult_iter32 #(.DONE_STICKY(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  mult_iter32 #(.DONE_STICKY(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] p;
  } vec_t;

  vec_t        vecs[18];
  logic [63:0] sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_exp_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] a, input logic [31:0] b, input logic s);
    b0.start = st; b0.op_a = a; b0.op_b = b; b0.sign_op = s;
    b1.start = st; b1.op_a = a; b1.op_b = b; b1.sign_op = s;
  endtask

  // Scoreboard: every done pulse of the pulse-mode DUT retires one expected product.
  always @(negedge clk) begin
    if (!reset && b0.done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with empty scoreboard, expected no done");
      end else begin
        check("product", {b0.hi, b0.lo}, sb.pop_front());
      end
    end
  end

  // Called at the negedge right after the accepting edge; kind 1 re-pulses start
  // mid-run, kind 2 raises start (and holds it) at cycle act_at.
  task automatic wait_done(input int act_at, input int kind, output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!b0.done && lat < 200) begin
      if (b0.busy) bcnt++;
      if (kind == 1 && lat == act_at) drive(1'b1, 32'd7, 32'd7, 1'b0);
      else if (kind == 1 && lat == act_at + 1) drive(1'b0, 32'd7, 32'd7, 1'b0);
      else if (kind == 2 && lat == act_at) drive(1'b1, 32'h1234, 32'h100, 1'b0);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] p);
    int lat, bcnt;
    @(negedge clk);
    drive(1'b1, a, b, s);
    sb.push_back(p);
    n_exp_done++;
    @(negedge clk);
    drive(1'b0, a, b, s);
    wait_done(-1, 0, lat, bcnt);
    check("latency", 64'(lat), 64'(LAT));
    check("busy_cycles", 64'(bcnt), 64'(LAT));
    check("busy_low_at_done", {63'd0, b0.busy}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt;
    vecs[0]  = '{32'd3,         32'd5,         1'b0, 64'h0000_0000_0000_000F};
    vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[2]  = '{32'd0,         32'h1234_5678, 1'b0, 64'h0};
    vecs[3]  = '{32'h1234_5678, 32'd0,         1'b0, 64'h0};
    vecs[4]  = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};
    vecs[5]  = '{32'h1234_5678, 32'h10,        1'b0, 64'h0000_0001_2345_6780};
    vecs[6]  = '{32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000};
    vecs[7]  = '{32'hFFFF_FFFE, 32'd3,         1'b0, 64'h0000_0002_FFFF_FFFA};
    vecs[8]  = '{32'hFFFF_FFFE, 32'd3,         1'b1,
                 SG ? 64'hFFFF_FFFF_FFFF_FFFA : 64'h0000_0002_FFFF_FFFA};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                 SG ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001};
    vecs[11] = '{32'd5,         32'hFFFF_FFFD, 1'b1,
                 SG ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1};
    vecs[12] = '{32'hFFFF_FFFD, 32'd5,         1'b1,
                 SG ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1};
    vecs[13] = '{32'd7,         32'hFFFF_FFFF, 1'b0, 64'h0000_0006_FFFF_FFF9};
    for (int i = 14; i < 18; i++) begin
      vecs[i].a = $urandom;
      vecs[i].b = $urandom;
      vecs[i].s = 1'b0;
      vecs[i].p = 64'(vecs[i].a) * 64'(vecs[i].b);
    end

    drive(1'b0, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, b0.busy}, 64'd0);
    check("reset_done", {63'd0, b0.done}, 64'd0);
    check("reset_hilo", {b0.hi, b0.lo}, 64'd0);
    check("reset_done_sticky", {63'd0, b1.done}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);

    // Sticky variant: done holds through idle cycles and clears on acceptance.
    check("sticky_product", {b1.hi, b1.lo}, vecs[17].p);
    check("sticky_done_set", {63'd0, b1.done}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sticky_done_hold", {63'd0, b1.done}, 64'd1);
      check("pulse_done_drop", {63'd0, b0.done}, 64'd0);
      check("hilo_hold_idle", {b0.hi, b0.lo}, vecs[17].p);
    end
    drive(1'b1, 32'd3, 32'd5, 1'b0);
    sb.push_back(64'hF);
    n_exp_done++;
    @(negedge clk);
    drive(1'b0, 32'd3, 32'd5, 1'b0);
    check("sticky_done_clear", {63'd0, b1.done}, 64'd0);
    check("sticky_busy_rise", {63'd0, b1.busy}, 64'd1);
    wait_done(-1, 0, lat, bcnt);
    check("latency_after_sticky", 64'(lat), 64'(LAT));

    // Start re-pulsed while busy must be ignored.
    @(negedge clk);
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0);
    sb.push_back(64'h0000_00DE_ADBE_EF00);
    n_exp_done++;
    @(negedge clk);
    drive(1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0);
    wait_done(10, 1, lat, bcnt);
    check("latency_repulse", 64'(lat), 64'(LAT));
    repeat (LAT + 4) @(negedge clk);
    check("no_second_done", 64'(n_done), 64'(n_exp_done));

    // Start raised in the DONE-state cycle is only taken on the following IDLE cycle.
    @(negedge clk);
    drive(1'b1, 32'd9, 32'd9, 1'b0);
    sb.push_back(64'd81);
    n_exp_done++;
    @(negedge clk);
    drive(1'b0, 32'd9, 32'd9, 1'b0);
    wait_done(LAT - 1, 2, lat, bcnt);
    check("latency_hold_start", 64'(lat), 64'(LAT));
    check("busy_low_in_done_cycle", {63'd0, b0.busy}, 64'd0);
    sb.push_back(64'h0012_3400);
    n_exp_done++;
    @(negedge clk);
    check("start_accepted_after_done", {63'd0, b0.busy}, 64'd1);
    drive(1'b0, 32'h1234, 32'h100, 1'b0);
    wait_done(-1, 0, lat, bcnt);
    check("latency_second", 64'(lat), 64'(LAT));

    // Reset at iteration 16 aborts the operation without a done pulse.
    @(negedge clk);
    drive(1'b1, 32'h0055_AA55, 32'h7777_7777, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0055_AA55, 32'h7777_7777, 1'b0);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {63'd0, b0.busy}, 64'd0);
    check("abort_done", {63'd0, b0.done}, 64'd0);
    check("abort_hilo", {b0.hi, b0.lo}, 64'd0);
    reset = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    check("abort_no_done", 64'(n_done), 64'(n_exp_done));
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);

    @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("done_count", 64'(n_done), 64'(n_exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
